// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with valid/ready handshake and a one-entry skid
// buffer. Upstream ready comes straight from a flop so decode never sees a
// combinational path from execute-stage backpressure or cache stalls.
module id_ex_skid_reg #(
  parameter int unsigned CTRL_W           = 8,
  parameter int unsigned DATA_W           = 116,
  parameter bit          FLUSH_CLEAR_DATA = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  logic accept;
  logic take;
  logic freed;

  assign in_ready_o  = ~skid_valid_q;
  assign accept      = in_valid_i & ~skid_valid_q;
  assign take        = main_valid_q & out_ready_i & ~stall_i;
  assign freed       = ~main_valid_q | take;

  assign out_valid_o = main_valid_q;
  assign out_ctrl_o  = main_ctrl_q;
  assign out_data_o  = main_data_q;
  assign occupancy_o = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  // Next-state selection: flush overrides, otherwise the skid refills main
  // first so ordering is kept, and input only lands in the skid when main
  // cannot move this cycle.
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (flush_i) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
      if (FLUSH_CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else if (freed) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl_i;
        main_data_d  = in_data_i;
      end else begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl_i;
      skid_data_d  = in_data_i;
    end
  end

  // Storage flops; asynchronous reset empties both entries.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed and randomized checks for id_ex_skid_reg with data clearing on flush.
module tb_id_ex_skid_reg;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [7:0]   in_ctrl_i;
  logic [115:0] in_data_i;
  logic         flush_i;
  logic         stall_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [7:0]   out_ctrl_o;
  logic [115:0] out_data_o;
  logic [1:0]   occupancy_o;

  int checks = 0;
  int errors = 0;

  logic [127:0] obs;
  logic [11:0]  obs_hdr;
  assign obs     = {in_ready_o, occupancy_o, out_valid_o, out_ctrl_o, out_data_o};
  assign obs_hdr = obs[127:116];

  id_ex_skid_reg #(
    .CTRL_W(8),
    .DATA_W(116),
    .FLUSH_CLEAR_DATA(1'b1)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .in_ctrl_i(in_ctrl_i),
    .in_data_i(in_data_i),
    .flush_i(flush_i),
    .stall_i(stall_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_ctrl_o(out_ctrl_o),
    .out_data_o(out_data_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [115:0] mkdata(input logic [7:0] c);
    return {4'hA, {14{c}}};
  endfunction

  // Expected {in_ready, occupancy, out_valid, out_ctrl, out_data}
  function automatic logic [127:0] exp_o(input logic rdy, input logic [1:0] occ,
                                         input logic v, input logic [7:0] c,
                                         input logic [115:0] d);
    return {rdy, occ, v, c, d};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic present(input logic v, input logic [7:0] c);
    in_valid_i = v;
    in_ctrl_i  = c;
    in_data_i  = mkdata(c);
  endtask

  task automatic test_reset();
    rst_i = 1'b0; in_valid_i = 1'b0; in_ctrl_i = '0; in_data_i = '0;
    flush_i = 1'b0; stall_i = 1'b0; out_ready_i = 1'b0;
    #3;
    checks++;
    if (obs !== exp_o(1'b1, 2'd0, 1'b0, 8'h00, '0)) begin
      errors++;
      $display("FAIL reset: got %h expected %h", obs, exp_o(1'b1, 2'd0, 1'b0, 8'h00, '0));
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    checks++;
    if (obs !== exp_o(1'b1, 2'd0, 1'b0, 8'h00, '0)) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", obs, exp_o(1'b1, 2'd0, 1'b0, 8'h00, '0));
    end
  endtask

  task automatic test_stream();
    logic [7:0] c;
    out_ready_i = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      c = 8'h11 + 8'(i);
      present(1'b1, c);
      tick();
      checks++;
      if (obs !== exp_o(1'b1, 2'd1, 1'b1, c, mkdata(c))) begin
        errors++;
        $display("FAIL stream[%0d]: got %h expected %h", i, obs, exp_o(1'b1, 2'd1, 1'b1, c, mkdata(c)));
      end
    end
    present(1'b0, 8'h00);
    tick();
    checks++;
    if (obs_hdr !== 12'h800) begin
      errors++;
      $display("FAIL stream_drain: got %h expected %h", obs_hdr, 12'h800);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] e [5];
    out_ready_i = 1'b0;
    e[0] = exp_o(1'b1, 2'd1, 1'b1, 8'h21, mkdata(8'h21));
    e[1] = exp_o(1'b0, 2'd2, 1'b1, 8'h21, mkdata(8'h21));
    e[2] = exp_o(1'b0, 2'd2, 1'b1, 8'h21, mkdata(8'h21));
    e[3] = exp_o(1'b1, 2'd1, 1'b1, 8'h22, mkdata(8'h22));
    e[4] = exp_o(1'b1, 2'd1, 1'b1, 8'h23, mkdata(8'h23));
    for (int unsigned i = 0; i < 5; i++) begin
      case (i)
        0: present(1'b1, 8'h21);
        1: present(1'b1, 8'h22);
        2: present(1'b1, 8'h23);
        3: out_ready_i = 1'b1;
        default: ;
      endcase
      tick();
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL backpressure[%0d]: got %h expected %h", i, obs, e[i]);
      end
    end
    present(1'b0, 8'h00);
    tick();
    checks++;
    if (obs_hdr !== 12'h800) begin
      errors++;
      $display("FAIL backpressure_drain: got %h expected %h", obs_hdr, 12'h800);
    end
  endtask

  task automatic test_stall();
    out_ready_i = 1'b1;
    stall_i = 1'b1;
    present(1'b1, 8'h41);
    tick();
    checks++;
    if (obs !== exp_o(1'b1, 2'd1, 1'b1, 8'h41, mkdata(8'h41))) begin
      errors++;
      $display("FAIL stall_fill1: got %h expected %h", obs, exp_o(1'b1, 2'd1, 1'b1, 8'h41, mkdata(8'h41)));
    end
    present(1'b1, 8'h42);
    tick();
    present(1'b0, 8'h00);
    for (int unsigned i = 0; i < 3; i++) begin
      checks++;
      if (obs !== exp_o(1'b0, 2'd2, 1'b1, 8'h41, mkdata(8'h41))) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs, exp_o(1'b0, 2'd2, 1'b1, 8'h41, mkdata(8'h41)));
      end
      if (i < 2) tick();
    end
    stall_i = 1'b0;
    tick();
    checks++;
    if (obs !== exp_o(1'b1, 2'd1, 1'b1, 8'h42, mkdata(8'h42))) begin
      errors++;
      $display("FAIL stall_release: got %h expected %h", obs, exp_o(1'b1, 2'd1, 1'b1, 8'h42, mkdata(8'h42)));
    end
    tick();
    checks++;
    if (obs_hdr !== 12'h800) begin
      errors++;
      $display("FAIL stall_drain: got %h expected %h", obs_hdr, 12'h800);
    end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    present(1'b1, 8'h51);
    tick();
    present(1'b1, 8'h52);
    tick();
    checks++;
    if (obs !== exp_o(1'b0, 2'd2, 1'b1, 8'h51, mkdata(8'h51))) begin
      errors++;
      $display("FAIL flush_full: got %h expected %h", obs, exp_o(1'b0, 2'd2, 1'b1, 8'h51, mkdata(8'h51)));
    end
    // flush together with a stall, a ready downstream and an incoming entry
    present(1'b1, 8'h53);
    flush_i = 1'b1; stall_i = 1'b1; out_ready_i = 1'b1;
    tick();
    checks++;
    if (obs !== exp_o(1'b1, 2'd0, 1'b0, 8'h00, '0)) begin
      errors++;
      $display("FAIL flush_empty: got %h expected %h", obs, exp_o(1'b1, 2'd0, 1'b0, 8'h00, '0));
    end
    flush_i = 1'b0; stall_i = 1'b0;
    present(1'b1, 8'h54);
    tick();
    checks++;
    if (obs !== exp_o(1'b1, 2'd1, 1'b1, 8'h54, mkdata(8'h54))) begin
      errors++;
      $display("FAIL flush_recover: got %h expected %h", obs, exp_o(1'b1, 2'd1, 1'b1, 8'h54, mkdata(8'h54)));
    end
    present(1'b0, 8'h00);
    tick();
  endtask

  task automatic test_async_reset();
    out_ready_i = 1'b1;
    present(1'b1, 8'h61);
    tick();
    present(1'b1, 8'h62);
    tick();
    checks++;
    if (obs !== exp_o(1'b1, 2'd1, 1'b1, 8'h62, mkdata(8'h62))) begin
      errors++;
      $display("FAIL arst_pre: got %h expected %h", obs, exp_o(1'b1, 2'd1, 1'b1, 8'h62, mkdata(8'h62)));
    end
    present(1'b1, 8'h63);
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if (obs !== exp_o(1'b1, 2'd0, 1'b0, 8'h00, '0)) begin
      errors++;
      $display("FAIL arst_immediate: got %h expected %h", obs, exp_o(1'b1, 2'd0, 1'b0, 8'h00, '0));
    end
    #2 rst_i = 1'b1;
    tick();
    checks++;
    if (obs !== exp_o(1'b1, 2'd1, 1'b1, 8'h63, mkdata(8'h63))) begin
      errors++;
      $display("FAIL arst_first_capture: got %h expected %h", obs, exp_o(1'b1, 2'd1, 1'b1, 8'h63, mkdata(8'h63)));
    end
    present(1'b0, 8'h00);
    tick();
    checks++;
    if (obs_hdr !== 12'h800) begin
      errors++;
      $display("FAIL arst_drain: got %h expected %h", obs_hdr, 12'h800);
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] seq = 8'd1;
    logic       acc, tk;
    int unsigned sz;
    for (int unsigned cyc = 0; cyc < 10000; cyc++) begin
      present(1'($urandom_range(0, 1)), seq);
      out_ready_i = 1'($urandom_range(0, 1));
      stall_i     = ($urandom_range(0, 3) == 0);
      flush_i     = ($urandom_range(0, 31) == 0);
      #0;
      sz = q.size();
      checks++;
      if (occupancy_o !== 2'(sz)) begin
        errors++;
        $display("FAIL rnd_occupancy@%0d: got %0d expected %0d", cyc, occupancy_o, sz);
      end
      checks++;
      if (in_ready_o !== (sz < 2)) begin
        errors++;
        $display("FAIL rnd_in_ready@%0d: got %b expected %b", cyc, in_ready_o, sz < 2);
      end
      checks++;
      if (sz > 0) begin
        if ({out_valid_o, out_ctrl_o, out_data_o} !== {1'b1, q[0], mkdata(q[0])}) begin
          errors++;
          $display("FAIL rnd_head@%0d: got %b/%h expected 1/%h", cyc, out_valid_o, out_ctrl_o, q[0]);
        end
      end else if ({out_valid_o, out_ctrl_o} !== 9'h000) begin
        errors++;
        $display("FAIL rnd_empty@%0d: got %b/%h expected 0/00", cyc, out_valid_o, out_ctrl_o);
      end
      acc = in_valid_i & (sz < 2);
      tk  = (sz > 0) & out_ready_i & ~stall_i;
      if (tk) void'(q.pop_front());
      if (flush_i) q.delete();
      else if (acc) begin
        q.push_back(seq);
        seq = (seq == 8'hFF) ? 8'd1 : seq + 8'd1;
      end
      tick();
    end
    flush_i = 1'b0; stall_i = 1'b0; in_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_skid_reg.md
# id_ex_skid_reg

Parametrised ID/EX pipeline register with a valid/ready handshake and a one-entry skid buffer. Upstream ready is a registered signal, so the decode stage never sees a combinational path from execute-stage backpressure. Downstream backpressure comes from execute-stage readiness or a cache stall. Flush inserts a bubble for branch or hazard recovery. It replaces the fixed-width ID/EX latch between decode and execute, and carries a control field (WB/MEM/EX bits) and an opaque data field (register operands, immediate, register addresses).

## Interface
- CTRL_W, 8, width of the control field; zeroed on every bubble.
- DATA_W, 116, width of the data payload (2×32 operands + 32 immediate + 4×5 addresses).
- FLUSH_CLEAR_DATA, 0, 1 = data entries are also zeroed on flush or reset-to-empty; 0 = data holds its last value.
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  decode presents an entry.
- in_ready_o  out  1  block can accept; registered, equals !skid_valid.
- in_ctrl_i  in  CTRL_W  control field of incoming entry.
- in_data_i  in  DATA_W  payload of incoming entry.
- flush_i  in  1  discard all held and incoming entries this cycle.
- stall_i  in  1  cache stall; blocks the output transfer only.
- out_valid_o  out  1  main entry valid.
- out_ready_i  in  1  execute stage can take the entry.
- out_ctrl_o  out  CTRL_W  main entry control; 0 whenever out_valid_o=0.
- out_data_o  out  DATA_W  main entry payload.
- occupancy_o  out  2  number of valid entries, 0..2.

## Operation
- Storage: main entry (drives outputs) and skid entry. Each has a valid bit, ctrl and data. The main entry is always older than the skid entry.
- accept = in_valid_i & in_ready_o.
- take = out_valid_o & out_ready_i & !stall_i.
- freed = !main_valid | take.
- Update rules when flush_i=0:
  - freed & skid_valid: main ← skid; skid becomes empty. accept is 0 here by construction.
  - freed & !skid_valid & accept: main ← input.
  - freed & !skid_valid & !accept: main becomes empty; ctrl ← 0.
  - !freed & accept: skid ← input; skid_valid ← 1.
  - Otherwise: hold.
- flush_i=1 has priority over every rule above:
  - Both valid bits and both ctrl fields go to 0.
  - Incoming entry is discarded even if accept=1.
  - A take in the same cycle still counts as consumed by downstream.
  - Data is zeroed only if FLUSH_CLEAR_DATA=1.
- stall_i only suppresses take. Input is still accepted into a free slot, so at most 2 entries are absorbed during a stall.
- occupancy_o = main_valid + skid_valid.
- No entry is ever duplicated, dropped (except by flush), or reordered.

## Timing
- Reset (rst_i=0, async):
  - All valid bits, ctrl fields and data go to 0.
  - Outputs: out_valid_o=0, out_ctrl_o=0, out_data_o=0, occupancy_o=0, in_ready_o=1.
- Latency: an entry accepted at edge N into an empty block appears on the outputs after edge N (one cycle).
- Throughput: 1 entry/cycle while take=1 every cycle; the skid stays empty.
- in_ready_o falls the cycle after an entry lands in the skid. It rises the cycle after the skid drains into main.
- Reset deasserted with in_valid_i=1: first capture at the first rising edge with rst_i=1.
- Reset asserted mid-operation: contents are lost immediately; no partial transfer is reported.
- Simultaneous take + accept with the skid empty: main is replaced by input; occupancy stays 1.
- Simultaneous flush + stall: flush wins; next cycle the block is empty and in_ready_o=1.

## Test plan
- Reset then stream: ctrl=8'h11..8'h15 with out_ready_i=1 → identical sequence out, each 1 cycle after input; in_ready_o stays 1; occupancy_o=1.
- Backpressure: send A, B, C with out_ready_i=0 → A held in main, B in skid, in_ready_o=0 from the cycle after B, C not accepted; release → A, B, C delivered in order with no gaps.
- Cache stall: stall_i=1 for 3 cycles while out_ready_i=1 and 2 entries are held → out_valid_o=1 with a stable payload, occupancy_o=2; on release, drains one per cycle.
- Flush with full buffer plus an incoming entry → next cycle out_valid_o=0, out_ctrl_o=0, occupancy_o=0, in_ready_o=1; with FLUSH_CLEAR_DATA=1, out_data_o=0.
- Async reset pulse mid-stream between clock edges → outputs are 0 immediately; after release, the next accepted entry appears 1 cycle later.
- Random valid/ready/stall (10k cycles, scoreboard) → in-order, lossless delivery; occupancy_o never exceeds 2; out_ctrl_o=0 whenever out_valid_o=0.
